// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//   Transmit-side frame controller for the UART Tx path. One byte is accepted
//   per i_send strobe while idle. The byte and parity mode are latched and
//   driven to the external parity unit. A frame is then serialised on o_tx:
//   a start bit, 8 data bits LSB-first, an optional parity bit returned on
//   i_parity, and a stop bit.
//
//   Optional feature macro: UART_TX_TWO_STOP_EN
//     When defined, the input i_stop_bits is added and latched with i_send.
//     0 selects one stop bit and 1 selects two stop bits.
//     When undefined, the frame always has one stop bit.
//
// Parameters
//   CLKS_PER_BIT   clock cycles per serial bit (>= 2)
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_stop_bits    (UART_TX_TWO_STOP_EN only) 0: one stop bit, 1: two stop bits
//   i_send         transmit request, accepted only when idle
//   i_data[7:0]    byte to send, sampled on an accepted request
//   i_parity_type  00/11 none, 01 odd, 10 even, sampled on an accepted request
//   i_parity       parity bit computed by the parity unit from o_reg
//   o_reg[7:0]     latched byte fed to the parity unit
//   o_par_type     latched parity mode fed to the parity unit
//   o_tx           serial line, idle high
//   o_busy         high from the cycle after accept until the frame ends
//   o_done         one-cycle pulse when the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
`ifdef UART_TX_TWO_STOP_EN
    input  logic       i_stop_bits,
`endif
    input  logic       i_send,
    input  logic [7:0] i_data,
    input  logic [1:0] i_parity_type,
    input  logic       i_parity,
    output logic [7:0] o_reg,
    output logic [1:0] o_par_type,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // A parity bit is sent only for odd (01) or even (10) modes.
    function automatic logic parity_enabled(input logic [1:0] ptype);
        logic en;
        case (ptype)
            2'b01:   en = 1'b1;
            2'b10:   en = 1'b1;
            default: en = 1'b0;
        endcase
        return en;
    endfunction

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [2:0]       r_idx, w_idx_nx;
    logic             r_tx, w_tx_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic [7:0]       r_reg, w_reg_nx;
    logic [1:0]       r_ptype, w_ptype_nx;
    logic             w_bit_end;
    logic             w_stop_last;
    logic [2:0]       w_idx_inc;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_idx_inc = r_idx + 3'd1;

`ifdef UART_TX_TWO_STOP_EN
    logic r_stop2, w_stop2_nx;
    // In STOP, r_idx counts stop bits; the second one ends a two-stop frame.
    assign w_stop_last = ~r_stop2 | (r_idx == 3'd1);

    // Stop-bit mode register, latched with the byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stop2 <= 1'b0;
        end else begin
            r_stop2 <= w_stop2_nx;
        end
    end
`else
    assign w_stop_last = 1'b1;
`endif

    // State, counters and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_reg   <= 8'h00;
            r_ptype <= 2'b00;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_reg   <= w_reg_nx;
            r_ptype <= w_ptype_nx;
        end
    end

    // Next-state and next-output logic; o_tx is computed one cycle ahead so
    // the line is driven straight from a flop.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_tx_nx    = r_tx;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_reg_nx   = r_reg;
        w_ptype_nx = r_ptype;
`ifdef UART_TX_TWO_STOP_EN
        w_stop2_nx = r_stop2;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tx_nx   = 1'b1;
                w_busy_nx = 1'b0;
                w_cnt_nx  = '0;
                w_idx_nx  = 3'd0;
                // A request in the Done cycle is dropped; a held request
                // starts a new frame one cycle later.
                if (i_send && !r_done) begin
                    w_reg_nx   = i_data;
                    w_ptype_nx = i_parity_type;
`ifdef UART_TX_TWO_STOP_EN
                    w_stop2_nx = i_stop_bits;
`endif
                    w_state_nx = ST_START;
                    w_tx_nx    = 1'b0;
                    w_busy_nx  = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nx = ST_DATA;
                    w_cnt_nx   = '0;
                    w_idx_nx   = 3'd0;
                    w_tx_nx    = r_reg[0];
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_idx == 3'd7) begin
                        w_idx_nx = 3'd0;
                        if (parity_enabled(r_ptype)) begin
                            // Parity is captured here and held for the bit.
                            w_state_nx = ST_PARITY;
                            w_tx_nx    = i_parity;
                        end else begin
                            w_state_nx = ST_STOP;
                            w_tx_nx    = 1'b1;
                        end
                    end else begin
                        w_idx_nx = w_idx_inc;
                        w_tx_nx  = r_reg[w_idx_inc];
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = ST_STOP;
                    w_cnt_nx   = '0;
                    w_idx_nx   = 3'd0;
                    w_tx_nx    = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                w_tx_nx = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (w_stop_last) begin
                        w_state_nx = ST_IDLE;
                        w_idx_nx   = 3'd0;
                        w_done_nx  = 1'b1;
                        w_busy_nx  = 1'b0;
                    end else begin
                        w_idx_nx = w_idx_inc;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_idx_nx   = 3'd0;
                w_tx_nx    = 1'b1;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign o_reg      = r_reg;
    assign o_par_type = r_ptype;
    assign o_tx       = r_tx;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with CLKS_PER_BIT = 4.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       send;
    logic [7:0] data;
    logic [1:0] ptype;
    logic       stop_bits;
    logic       tb_parity;
    logic [7:0] o_reg;
    logic [1:0] o_par_type;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    int tests;
    int fails;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
`ifdef UART_TX_TWO_STOP_EN
        .i_stop_bits   (stop_bits),
`endif
        .i_send        (send),
        .i_data        (data),
        .i_parity_type (ptype),
        .i_parity      (tb_parity),
        .o_reg         (o_reg),
        .o_par_type    (o_par_type),
        .o_tx          (o_tx),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    // External parity unit: odd mode makes total ones odd, otherwise even.
    assign tb_parity = (o_par_type == 2'b01) ? ~(^o_reg) : (^o_reg);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame and checks every bit cycle. exp[i] is the i-th bit on
    // the line (bit 0 = start). Returns at the Done cycle after checking it.
    task automatic check_frame(input string nm, input logic [7:0] d,
                               input logic [1:0] pt, input logic sb,
                               input logic [10:0] exp, input int nbits,
                               input bit inject, input bit hold);
        send      = 1'b1;
        data      = d;
        ptype     = pt;
        stop_bits = sb;
        step();
        if (!hold) send = 1'b0;
        data  = ~d;
        ptype = ~pt;
        tests++;
        if (o_reg !== d || o_par_type !== pt) begin
            fails++;
            $display("FAIL %s latch: reg=%h ptype=%b, want reg=%h ptype=%b", nm, o_reg, o_par_type, d, pt);
        end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (inject && b == 4 && c == 1) begin
                    send = 1'b1;
                    data = 8'hFF;
                end else if (inject && b == 4 && c == 2) begin
                    send = 1'b0;
                end
                tests++;
                if (o_tx !== exp[b] || o_busy !== 1'b1 || o_done !== 1'b0) begin
                    fails++;
                    $display("FAIL %s bit%0d cyc%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                             nm, b, c, o_tx, o_busy, o_done, exp[b]);
                end
                step();
            end
        end
        tests++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_tx !== 1'b1 || o_reg !== d) begin
            fails++;
            $display("FAIL %s done: done=%b busy=%b tx=%b reg=%h, want done=1 busy=0 tx=1 reg=%h",
                     nm, o_done, o_busy, o_tx, o_reg, d);
        end
    endtask

    // Checks the line stays idle for n cycles.
    task automatic check_idle(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            tests++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                fails++;
                $display("FAIL %s idle cyc%0d: tx=%b busy=%b done=%b, want 1 0 0", nm, i, o_tx, o_busy, o_done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tests++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_reg !== 8'h00 || o_par_type !== 2'b00) begin
                fails++;
                $display("FAIL reset cyc%0d: tx=%b busy=%b done=%b reg=%h pt=%b, want 1 0 0 00 00",
                         i, o_tx, o_busy, o_done, o_reg, o_par_type);
            end
            step();
        end
    endtask

    task automatic test_parity_modes();
        check_frame("a5_odd",  8'hA5, 2'b01, 1'b0, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0, 1'b0);
        check_idle("a5_odd", 3);
        check_frame("07_even", 8'h07, 2'b10, 1'b0, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 1'b0);
        check_idle("07_even", 3);
        check_frame("07_none00", 8'h07, 2'b00, 1'b0, {1'b0, 1'b1, 8'h07, 1'b0}, 10, 1'b0, 1'b0);
        check_idle("07_none00", 3);
        check_frame("07_none11", 8'h07, 2'b11, 1'b0, {1'b0, 1'b1, 8'h07, 1'b0}, 10, 1'b0, 1'b0);
        check_idle("07_none11", 3);
        // Even parity of 8'h01 is 1, odd parity of 8'h03 is 1, even of 8'h03 is 0.
        check_frame("03_even", 8'h03, 2'b10, 1'b0, {1'b1, 1'b0, 8'h03, 1'b0}, 11, 1'b0, 1'b0);
        check_idle("03_even", 3);
    endtask

    task automatic test_ignore_send();
        check_frame("ignore", 8'h96, 2'b00, 1'b0, {1'b0, 1'b1, 8'h96, 1'b0}, 10, 1'b1, 1'b0);
        check_idle("ignore", 12);
    endtask

    task automatic test_mid_reset();
        send  = 1'b1;
        data  = 8'hA5;
        ptype = 2'b01;
        step();
        send = 1'b0;
        repeat (CPB + CPB * 3 + 2) step();
        rst_n = 1'b0;
        #1;
        tests++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_reg !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset: tx=%b busy=%b done=%b reg=%h, want 1 0 0 00", o_tx, o_busy, o_done, o_reg);
        end
        step();
        rst_n = 1'b1;
        check_idle("post_reset", 2);
        check_frame("after_reset", 8'hA5, 2'b01, 1'b0, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0, 1'b0);
        check_idle("after_reset", 2);
    endtask

    task automatic test_back_to_back();
        bit seen;
        check_frame("hold", 8'hA5, 2'b01, 1'b0, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0, 1'b1);
        step();
        tests++;
        if (o_done !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_done_cycle: done=%b tx=%b busy=%b, want 0 1 0", o_done, o_tx, o_busy);
        end
        step();
        tests++;
        if (o_tx !== 1'b0 || o_busy !== 1'b1 || o_reg !== 8'h5A) begin
            fails++;
            $display("FAIL hold_retrigger: tx=%b busy=%b reg=%h, want 0 1 5a", o_tx, o_busy, o_reg);
        end
        send = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (o_done === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL hold_second_done: done not seen within 100 cycles, want done pulse");
        end
        check_idle("hold_end", 2);
    endtask

`ifdef UART_TX_TWO_STOP_EN
    task automatic test_two_stop();
        check_frame("two_stop", 8'h3C, 2'b00, 1'b1, {1'b1, 1'b1, 8'h3C, 1'b0}, 11, 1'b0, 1'b0);
        check_idle("two_stop", 3);
        check_frame("one_stop", 8'h3C, 2'b00, 1'b0, {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 1'b0);
        check_idle("one_stop", 3);
    endtask
`endif

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        send      = 1'b0;
        data      = 8'h00;
        ptype     = 2'b00;
        stop_bits = 1'b0;
        test_reset();
        test_parity_modes();
        test_ignore_send();
        test_mid_reset();
        test_back_to_back();
`ifdef UART_TX_TWO_STOP_EN
        test_two_stop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
